// File: rtl/alu16_seq_ctrl_if.sv
// Request/response and ALU control bundle for the ALU sequencing controller.
// The slave view belongs to the controller; master is the requester plus the ALU.
interface alu16_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_cin;
    logic             alu_ainvert;
    logic             alu_bnegate;
    logic             alu_less;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             alu_cout;
    logic             alu_overflow;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             ovf;
    logic             err;

    modport slave (
        input  start, opcode, a_in, b_in,
        input  alu_result, alu_cout, alu_overflow,
        output alu_a, alu_b, alu_cin, alu_ainvert,
        output alu_bnegate, alu_less, alu_op,
        output busy, done, result, zero, carry, ovf, err
    );

    modport master (
        output start, opcode, a_in, b_in,
        output alu_result, alu_cout, alu_overflow,
        input  alu_a, alu_b, alu_cin, alu_ainvert,
        input  alu_bnegate, alu_less, alu_op,
        input  busy, done, result, zero, carry, ovf, err
    );
endinterface

// File: rtl/alu16_seq_ctrl.sv
// Sequences single-pass ops, two-pass SLT and a shift-add multiply
// through one shared 16-bit ALU behind a start/busy/done handshake.
module alu16_seq_ctrl #(
    parameter int WIDTH     = 16,
    parameter int MUL_STEPS = 16
) (
    input  logic             clk,
    input  logic             reset,
    alu16_seq_ctrl_if.slave  bus
);
    localparam int CW = $clog2(MUL_STEPS);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    typedef enum logic [2:0] {
        IDLE, EXEC, SLT2, MUL, DONE
    } state_t;

    state_t           state, state_nx;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    cnt;
    logic             slt_q, zero_q, carry_q, ovf_q, err_q;

    logic [WIDTH-1:0] alu_a, alu_b, acc_nx;
    logic             alu_cin, alu_ainv, alu_bneg, alu_less;
    logic [1:0]       alu_op;
    logic             last, addsub;

    assign last   = (cnt == CW'(MUL_STEPS - 1));
    assign addsub = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign acc_nx = mplier[0] ? bus.alu_result : acc;

    always_comb begin
        state_nx = state;
        alu_a    = '0;
        alu_b    = '0;
        alu_cin  = 1'b0;
        alu_ainv = 1'b0;
        alu_bneg = 1'b0;
        alu_less = 1'b0;
        alu_op   = 2'b00;
        unique case (state)
            IDLE: begin
                if (bus.start)
                    state_nx = (bus.opcode == OP_MUL) ? MUL : EXEC;
            end
            EXEC: begin
                alu_a = a_q;
                alu_b = b_q;
                unique case (op_q)
                    OP_AND: alu_op = 2'b00;
                    OP_OR:  alu_op = 2'b01;
                    OP_ADD: alu_op = 2'b10;
                    OP_SUB, OP_SLT: begin
                        alu_op   = 2'b10;
                        alu_bneg = 1'b1;
                        alu_cin  = 1'b1;
                    end
                    // NOR as AND of the inverted operands
                    OP_NOR: begin
                        alu_op   = 2'b00;
                        alu_ainv = 1'b1;
                        alu_bneg = 1'b1;
                    end
                    default: begin
                        alu_a = '0;
                        alu_b = '0;
                    end
                endcase
                state_nx = (op_q == OP_SLT) ? SLT2 : DONE;
            end
            SLT2: begin
                alu_op   = 2'b11;
                alu_less = slt_q;
                state_nx = DONE;
            end
            MUL: begin
                alu_op = 2'b10;
                alu_a  = acc;
                alu_b  = mcand;
                if (last)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= OP_AND;
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            res_q   <= '0;
            slt_q   <= 1'b0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q <= bus.opcode;
                        a_q  <= bus.a_in;
                        b_q  <= bus.b_in;
                        if (bus.opcode == OP_MUL) begin
                            acc     <= '0;
                            mcand   <= bus.a_in;
                            mplier  <= bus.b_in;
                            cnt     <= '0;
                            carry_q <= 1'b0;
                        end
                    end
                end
                EXEC: begin
                    if (op_q == OP_ILL) begin
                        res_q   <= '0;
                        zero_q  <= 1'b1;
                        err_q   <= 1'b1;
                        carry_q <= 1'b0;
                        ovf_q   <= 1'b0;
                    end else begin
                        res_q   <= bus.alu_result;
                        zero_q  <= (bus.alu_result == '0);
                        err_q   <= 1'b0;
                        carry_q <= addsub & bus.alu_cout;
                        ovf_q   <= addsub & bus.alu_overflow;
                    end
                    slt_q <= bus.alu_result[WIDTH-1]
                             ^ bus.alu_overflow;
                end
                SLT2: begin
                    res_q  <= bus.alu_result;
                    zero_q <= (bus.alu_result == '0);
                end
                MUL: begin
                    acc     <= acc_nx;
                    carry_q <= carry_q | (mplier[0] & bus.alu_cout);
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    cnt     <= cnt + CW'(1);
                    if (last) begin
                        res_q  <= acc_nx;
                        zero_q <= (acc_nx == '0);
                        ovf_q  <= 1'b0;
                        err_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.alu_a       = alu_a;
    assign bus.alu_b       = alu_b;
    assign bus.alu_cin     = alu_cin;
    assign bus.alu_ainvert = alu_ainv;
    assign bus.alu_bnegate = alu_bneg;
    assign bus.alu_less    = alu_less;
    assign bus.alu_op      = alu_op;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.result      = res_q;
    assign bus.zero        = zero_q;
    assign bus.carry       = carry_q;
    assign bus.ovf         = ovf_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_alu16_seq_ctrl.sv
// Bench for alu16_seq_ctrl: behavioural ALU fixture, arithmetic reference
// model, directed plan vectors and randomized operations.
module tb_alu16_seq_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu16_seq_ctrl_if bus ();

    alu16_seq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the shared 16-bit ALU.
    logic [15:0] ae, be;
    logic [16:0] sum;
    always_comb begin
        ae = bus.alu_ainvert ? ~bus.alu_a : bus.alu_a;
        be = bus.alu_bnegate ? ~bus.alu_b : bus.alu_b;
        sum = {1'b0, ae} + {1'b0, be} + {16'd0, bus.alu_cin};
        bus.alu_cout = sum[16];
        bus.alu_overflow = (ae[15] == be[15]) && (sum[15] != ae[15]);
        case (bus.alu_op)
            2'b00:   bus.alu_result = ae & be;
            2'b01:   bus.alu_result = ae | be;
            2'b10:   bus.alu_result = sum[15:0];
            default: bus.alu_result = {15'd0, bus.alu_less};
        endcase
    end

    function automatic void model(input logic [2:0] op,
                                  input logic [15:0] a,
                                  input logic [15:0] b,
                                  output logic [15:0] r,
                                  output logic c,
                                  output logic o,
                                  output logic e);
        int ua, ub, sa, sb, t, acc;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        r = 16'd0; c = 1'b0; o = 1'b0; e = 1'b0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin
                t = ua + ub;
                r = 16'(t);
                c = (t > 65535);
                t = sa + sb;
                o = (t > 32767) || (t < -32768);
            end
            3'd3: begin
                r = 16'(ua - ub);
                c = (ua >= ub);
                t = sa - sb;
                o = (t > 32767) || (t < -32768);
            end
            3'd4: r = ~(a | b);
            3'd5: r = (sa < sb) ? 16'd1 : 16'd0;
            3'd6: begin
                r = 16'(ua * ub);
                acc = 0;
                for (int i = 0; i < 16; i++) begin
                    if (b[i]) begin
                        acc = acc + ((ua << i) & 32'hFFFF);
                        if (acc > 65535) c = 1'b1;
                        acc = acc & 32'hFFFF;
                    end
                end
            end
            default: e = 1'b1;
        endcase
    endfunction

    task automatic do_op(input string nm, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b,
                         input bit poke);
        logic [15:0] er;
        logic ec, eo, ee;
        int lat, want;
        bit busy_ok;
        model(op, a, b, er, ec, eo, ee);
        want = (op == 3'd6) ? 17 : (op == 3'd5) ? 3 : 2;
        @(negedge clk);
        bus.start = 1'b1;
        bus.opcode = op;
        bus.a_in = a;
        bus.b_in = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.opcode = 3'($urandom);
        bus.a_in = 16'($urandom);
        bus.b_in = 16'($urandom);
        lat = -1;
        busy_ok = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.done === 1'b1) begin
                lat = cyc;
                break;
            end
            if (poke) begin
                bus.start = 1'b1;
                bus.opcode = 3'($urandom);
                bus.a_in = 16'($urandom);
                bus.b_in = 16'($urandom);
            end
        end
        bus.start = 1'b0;
        checks++;
        if (lat != want) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", nm, lat, want);
        end
        checks++;
        if (busy_ok !== 1'b1) begin
            errors++;
            $display("FAIL %s busy dropped before done got 0 want 1", nm);
        end
        checks++;
        if (bus.result !== er) begin
            errors++;
            $display("FAIL %s result got %h want %h", nm, bus.result, er);
        end
        checks++;
        if (bus.zero !== (er == 16'd0)) begin
            errors++;
            $display("FAIL %s zero got %b want %b", nm, bus.zero, er == 16'd0);
        end
        checks++;
        if (bus.carry !== ec) begin
            errors++;
            $display("FAIL %s carry got %b want %b", nm, bus.carry, ec);
        end
        checks++;
        if (bus.ovf !== eo) begin
            errors++;
            $display("FAIL %s ovf got %b want %b", nm, bus.ovf, eo);
        end
        checks++;
        if (bus.err !== ee) begin
            errors++;
            $display("FAIL %s err got %b want %b", nm, bus.err, ee);
        end
    endtask

    task automatic check_idle(input string nm);
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after done busy/done got %b%b want 00",
                     nm, bus.busy, bus.done);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.zero, bus.carry, bus.ovf, bus.err}
            !== 6'd0 || bus.result !== 16'd0) begin
            errors++;
            $display("FAIL reset status got %b%b%b%b%b%b res %h want 0",
                     bus.busy, bus.done, bus.zero, bus.carry, bus.ovf,
                     bus.err, bus.result);
        end
        checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_ainvert,
             bus.alu_bnegate, bus.alu_less, bus.alu_op} !== 38'd0) begin
            errors++;
            $display("FAIL reset alu drive got op %b a %h b %h want 0",
                     bus.alu_op, bus.alu_a, bus.alu_b);
        end
    endtask

    task automatic test_directed();
        do_op("sub_f_e", 3'd3, 16'h000F, 16'h000E, 1'b0);
        check_idle("sub_f_e");
        do_op("sub_small", 3'd3, 16'd1001, 16'd12341, 1'b0);
        check_idle("sub_small");
        do_op("add_ovf", 3'd2, 16'h7FFF, 16'h0001, 1'b0);
        check_idle("add_ovf");
        do_op("slt_pos", 3'd5, 16'd1001, 16'd12341, 1'b0);
        do_op("slt_neg", 3'd5, 16'h8000, 16'h0001, 1'b0);
        do_op("slt_eq", 3'd5, 16'd5, 16'd5, 1'b0);
        do_op("and", 3'd0, 16'h00F0, 16'h0FF0, 1'b0);
        do_op("or", 3'd1, 16'h00F0, 16'h0FF0, 1'b0);
        do_op("nor", 3'd4, 16'h00F0, 16'h0FF0, 1'b0);
        do_op("illegal", 3'd7, 16'h1234, 16'h5678, 1'b0);
    endtask

    task automatic test_mul();
        do_op("mul_300_200", 3'd6, 16'd300, 16'd200, 1'b0);
        check_idle("mul_300_200");
        do_op("mul_zero", 3'd6, 16'h0100, 16'h0100, 1'b0);
        do_op("mul_carry", 3'd6, 16'hFFFF, 16'hFFFF, 1'b0);
    endtask

    task automatic test_busy_ignore();
        do_op("busy_mul", 3'd6, 16'd1234, 16'd77, 1'b1);
        check_idle("busy_mul");
        do_op("busy_slt", 3'd5, 16'hFFFE, 16'h0003, 1'b1);
        check_idle("busy_slt");
    endtask

    task automatic test_back_to_back();
        do_op("b2b_add", 3'd2, 16'hFFFF, 16'h0002, 1'b0);
        bus.start = 1'b1;
        bus.opcode = 3'd6;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b start_in_done busy got %b want 0", bus.busy);
        end
    endtask

    task automatic test_reset_abort();
        bit saw_done;
        @(negedge clk);
        bus.start = 1'b1;
        bus.opcode = 3'd6;
        bus.a_in = 16'd300;
        bus.b_in = 16'd200;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 16'd0) begin
            errors++;
            $display("FAIL abort state busy %b done %b res %h want 0 0 0000",
                     bus.busy, bus.done, bus.result);
        end
        saw_done = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL abort late activity got 1 want 0");
        end
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [15:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a = 16'($urandom);
            b = 16'($urandom);
            if (i % 5 == 0) a = 16'h8000;
            if (i % 7 == 0) b = a;
            do_op("random", op, a, b, 1'b0);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.opcode = 3'd0;
        bus.a_in = 16'd0;
        bus.b_in = 16'd0;
        test_reset();
        test_directed();
        test_mul();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu16_seq_ctrl.md
Name: alu16_seq_ctrl

Overview:
Sequencing controller that owns one alu16Bit instance and turns opcode requests into ALU control-line settings.
- Single-pass ops (AND/OR/ADD/SUB/NOR) take one ALU pass.
- Set-less-than (SLT) takes two passes.
- 16x16 multiply (low 16 bits of the product) is a 16-step shift-add loop through the ALU adder.
- Sits between the CPU_16Bit decode stage and the shared ALU; presents a start/busy/done handshake.

Parameters:
- WIDTH, 16, operand/result width; fixed to the ALU width.
- MUL_STEPS, 16, multiply iterations; must equal WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- start  input  1  request strobe; sampled only when busy=0
- opcode  input  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 NOR, 101 SLT, 110 MUL, 111 illegal
- a_in  input  16  operand A
- b_in  input  16  operand B
- alu_a  output  16  ALU operand A
- alu_b  output  16  ALU operand B
- alu_cin  output  1  ALU carry-in
- alu_ainvert  output  1  ALU invert-A
- alu_bnegate  output  1  ALU negate-B
- alu_less  output  1  ALU less input
- alu_op  output  2  ALU op: 00 AND, 01 OR, 10 ADD, 11 LESS
- alu_result  input  16  ALU result
- alu_cout  input  1  ALU carry-out
- alu_overflow  input  1  ALU overflow
- busy  output  1  high from accept until done
- done  output  1  one-cycle pulse; result and flags valid
- result  output  16  registered result
- zero  output  1  result==0; registered with result
- carry  output  1  ADD/SUB: alu_cout; MUL: sticky OR of alu_cout on accumulate steps; else 0
- ovf  output  1  ADD/SUB: alu_overflow; else 0
- err  output  1  illegal opcode

Behaviour:
- Reset (synchronous, active-high):
  - FSM to IDLE.
  - busy, done, result, zero, carry, ovf, err all go to 0.
  - All alu_* control outputs go to 0.
  - Reset mid-operation aborts; done is never asserted for an aborted op.
- States: IDLE, EXEC, SLT2, MUL, DONE.
- IDLE:
  - start=1 latches opcode, a_in, b_in; busy goes to 1 the next cycle.
  - opcode 110 goes to MUL with acc=0, mcand=A, mplier=B, cnt=0, carry cleared.
  - All other opcodes go to EXEC.
- start while busy=1: ignored; no latch, no queue.
- ALU drive is combinational from the state and latched registers:
  - AND: op=00, cin/ainv/bneg=0.
  - OR: op=01.
  - ADD: op=10, cin=0.
  - SUB: op=10, bneg=1, cin=1.
  - NOR: op=00, ainv=1, bneg=1 (AND of inverted operands).
  - SLT pass 1: same as SUB.
- EXEC: capture alu_result, or 0 for illegal.
  - Set carry/ovf per the port rules.
  - SLT: store slt = alu_result[15] XOR alu_overflow, then go to SLT2.
  - Illegal: err=1, result=0.
  - All others go to DONE.
- SLT2: drive alu_op=11, alu_less=slt, alu_a=alu_b=0; capture alu_result (expected {15'b0,slt}); go to DONE.
- MUL, one step per cycle:
  - Drive ADD with alu_a=acc, alu_b=mcand.
  - If mplier[0]=1: acc <= alu_result and carry |= alu_cout; otherwise acc holds.
  - mcand <<= 1 (zero fill), mplier >>= 1 logical, cnt++.
  - After the step with cnt=15, result <= final acc and go to DONE.
  - No early exit; ALU outputs are don't-care for skipped adds.
- DONE: done=1 for exactly one cycle; busy is still 1. Then go to IDLE with busy=0.
  - A start in the same cycle as done is ignored.
- zero is computed from the registered result, not from the ALU zero output.
- result/flags hold their value until the next op's capture.
- Latency (start sampled at edge 0):
  - Single ops and illegal: done high in cycle 2.
  - SLT: done high in cycle 3.
  - MUL: done high in cycle 17.
- All arithmetic is modulo 2^16; operands are unsigned except for SLT, which compares as signed two's complement.

Test Plan:
- Reset, then SUB with a=0x000F, b=0x000E -> done in cycle 2; result=0x0001, carry=1, ovf=0, zero=0.
- SUB with a=1001, b=12341 -> result=0xD3B4, carry=0, ovf=0; then ADD with a=0x7FFF, b=0x0001 -> result=0x8000, ovf=1.
- SLT with a=1001, b=12341 -> result=1 in cycle 3. SLT with a=0x8000, b=0x0001 -> result=1 (signed). SLT with a=5, b=5 -> result=0, zero=1.
- AND/OR/NOR with a=0x00F0, b=0x0FF0 -> results 0x00F0, 0x0FF0, 0xF00F.
- MUL with a=300, b=200 -> result=0xEA60, carry=0, done in cycle 17, busy high cycles 1-17.
- MUL with a=0x0100, b=0x0100 -> result=0, zero=1. Exercise start pulses during busy (ignored), reset asserted at MUL step 8 (busy=0 next cycle, no done), and opcode 111 (err=1, result=0).
